// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-buffer stream width converters.
package ring_pkg;

  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

  // Map the running flit counter onto the word slice that goes out next.
  function automatic int flit_index(input int cnt, input int ratio, input bit lsb_first);
    return lsb_first ? cnt : (ratio - 1 - cnt);
  endfunction

endpackage

// File: rtl/ring_serializer.sv
// Width-down converter: one DATA_SIZE-bit word in, RATIO FLIT_SIZE-bit flits out,
// valid/ack on both sides with no bubble between back-to-back words.
module ring_serializer
  import ring_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int FLIT_SIZE = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 rx_ack_o,
  input  logic [DATA_SIZE-1:0] data_i,
  output logic                 tx_o,
  input  logic                 tx_ack_i,
  output logic [FLIT_SIZE-1:0] data_o
);

  localparam int RATIO = DATA_SIZE / FLIT_SIZE;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  ser_state_t           state_q, state_d;
  logic [DATA_SIZE-1:0] word_q, word_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [FLIT_SIZE-1:0] flits [RATIO];
  logic [CNT_W-1:0]     flit_sel;
  logic                 sending;
  logic                 last_accept;
  logic                 capture;

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    assign flits[i] = word_q[i*FLIT_SIZE +: FLIT_SIZE];
  end

  // Handshake outputs; the ready path from tx_ack_i is combinational by design.
  always_comb begin
    sending     = (state_q == SER_SEND);
    last_accept = sending && (cnt_q == LAST_CNT) && tx_ack_i;
    rx_ack_o    = !sending || last_accept;
    capture     = rx_i && rx_ack_o;
    flit_sel    = CNT_W'(flit_index(32'(cnt_q), RATIO, LSB_FIRST));
    tx_o        = sending;
    data_o      = flits[flit_sel];
  end

  always_comb begin
    // NOTE: every next-state variable is defaulted to its current value first,
    // so no path through the branches below can leave one unassigned (no latch).
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (capture) begin
      word_d  = data_i;
      cnt_d   = '0;
      state_d = SER_SEND;
    end else if (sending && tx_ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last_accept) begin
        state_d = SER_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SER_IDLE;
      // NOTE: the word register is reset even though its contents are don't-care
      // when idle, because data_o is driven from it and must never show X.
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_word_multiple: assert property (@(posedge clk_i) (DATA_SIZE % FLIT_SIZE) == 0);
  a_ratio_pow2:    assert property (@(posedge clk_i) (RATIO >= 2) && ((RATIO & (RATIO - 1)) == 0));
  a_tx_hold:       assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    (tx_o && !tx_ack_i) |=> (tx_o && $stable(data_o)));
`endif

endmodule

// File: tb/tb_ring_serializer.sv
// Bench for ring_serializer: LSB-first and MSB-first instances share one stimulus;
// directed table, random scoreboard run and an asynchronous mid-word reset.
module tb_ring_serializer;

  localparam int DW    = 32;
  localparam int FW    = 8;
  localparam int RATIO = DW / FW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          rx_i;
  logic [DW-1:0] data_i;
  logic          tx_ack_i;
  logic          rx_ack_l, rx_ack_m;
  logic          tx_l, tx_m;
  logic [FW-1:0] data_l, data_m;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ring_serializer #(.DATA_SIZE(DW), .FLIT_SIZE(FW), .LSB_FIRST(1'b1)) u_lsb (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .rx_ack_o(rx_ack_l), .data_i(data_i),
    .tx_o(tx_l), .tx_ack_i(tx_ack_i), .data_o(data_l)
  );

  ring_serializer #(.DATA_SIZE(DW), .FLIT_SIZE(FW), .LSB_FIRST(1'b0)) u_msb (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .rx_ack_o(rx_ack_m), .data_i(data_i),
    .tx_o(tx_m), .tx_ack_i(tx_ack_i), .data_o(data_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rx, input logic [DW-1:0] d, input logic ack);
    rx_i     = rx;
    data_i   = d;
    tx_ack_i = ack;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic          rx;
    logic [DW-1:0] d;
    logic          ack;
    logic          e_tx;
    logic          e_rxack;
    logic          chk_d;
    logic [FW-1:0] e_l;
    logic [FW-1:0] e_m;
  } vec_t;

  vec_t vecs[$];

  // Reference: the flits still owed downstream, per output order.
  logic [FW-1:0] ql[$];
  logic [FW-1:0] qm[$];

  task automatic push_word(input logic [DW-1:0] w);
    for (int i = 0; i < RATIO; i++) begin
      ql.push_back(w[FW*i +: FW]);
      qm.push_back(w[FW*(RATIO-1-i) +: FW]);
    end
  endtask

  // One random cycle: compare against the model, then advance the model.
  task automatic model_cycle(output logic accepted);
    logic exp_tx, exp_ack;
    accepted = 1'b0;
    @(negedge clk_i);
    exp_tx  = (ql.size() != 0);
    exp_ack = (ql.size() == 0) || (ql.size() == 1 && tx_ack_i);
    check("rnd_tx_lsb", 32'(tx_l), 32'(exp_tx));
    check("rnd_tx_msb", 32'(tx_m), 32'(exp_tx));
    check("rnd_rxack_lsb", 32'(rx_ack_l), 32'(exp_ack));
    check("rnd_rxack_msb", 32'(rx_ack_m), 32'(exp_ack));
    if (exp_tx) begin
      check("rnd_data_lsb", 32'(data_l), 32'(ql[0]));
      check("rnd_data_msb", 32'(data_m), 32'(qm[0]));
      if (tx_ack_i) begin
        void'(ql.pop_front());
        void'(qm.pop_front());
      end
    end
    if (rx_i && exp_ack) begin
      push_word(data_i);
      accepted = 1'b1;
    end
    next_cycle();
  endtask

  initial begin
    int   words;
    int   cyc;
    logic acc;

    drive(1'b0, '0, 1'b0);
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_tx", 32'(tx_l | tx_m), 32'd0);
    check("rst_rxack", 32'({rx_ack_l, rx_ack_m}), 32'd3);
    check("rst_data_lsb", 32'(data_l), 32'd0);
    check("rst_data_msb", 32'(data_m), 32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check("idle_tx", 32'({tx_l, tx_m}), 32'd0);
    end

    // rx, data, ack | tx, rxack, check data, lsb flit, msb flit
    vecs.push_back('{1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 8'hD4, 8'hA1});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'hB2});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 8'hB2, 8'hC3});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 8'hD4});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 32'h11223344, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 8'h11});
    vecs.push_back('{1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 8'h22});
    vecs.push_back('{1'b1, 32'h55667788, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 8'h33});
    vecs.push_back('{1'b1, 32'h55667788, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h44});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 8'h88, 8'h55});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 8'h66});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 8'h66});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 8'h77});
    vecs.push_back('{1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 8'h88});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h88});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00});

    foreach (vecs[i]) begin
      drive(vecs[i].rx, vecs[i].d, vecs[i].ack);
      @(negedge clk_i);
      check($sformatf("vec%0d_tx_lsb", i), 32'(tx_l), 32'(vecs[i].e_tx));
      check($sformatf("vec%0d_tx_msb", i), 32'(tx_m), 32'(vecs[i].e_tx));
      check($sformatf("vec%0d_rxack_lsb", i), 32'(rx_ack_l), 32'(vecs[i].e_rxack));
      check($sformatf("vec%0d_rxack_msb", i), 32'(rx_ack_m), 32'(vecs[i].e_rxack));
      if (vecs[i].chk_d) begin
        check($sformatf("vec%0d_data_lsb", i), 32'(data_l), 32'(vecs[i].e_l));
        check($sformatf("vec%0d_data_msb", i), 32'(data_m), 32'(vecs[i].e_m));
      end
      next_cycle();
    end

    words = 0;
    cyc   = 0;
    while (words < 1000 && cyc < 30000) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 3);
      model_cycle(acc);
      if (acc) words++;
      cyc++;
    end
    check("rnd_words_budget", 32'(words), 32'd1000);
    cyc = 0;
    while (ql.size() != 0 && cyc < 500) begin
      drive(1'b0, $urandom, $urandom_range(0, 9) < 3);
      model_cycle(acc);
      cyc++;
    end
    check("rnd_drain", 32'(ql.size()), 32'd0);

    drive(1'b1, 32'hDEADBEEF, 1'b1);
    next_cycle();
    drive(1'b0, '0, 1'b1);
    next_cycle();
    next_cycle();
    check("midrst_pre_data_lsb", 32'(data_l), 32'hAD);
    check("midrst_pre_tx", 32'({tx_l, tx_m}), 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_tx", 32'({tx_l, tx_m}), 32'd0);
    check("midrst_rxack", 32'({rx_ack_l, rx_ack_m}), 32'd3);
    check("midrst_data", 32'({data_l, data_m}), 32'd0);
    next_cycle();
    rst_ni = 1'b1;
    next_cycle();
    drive(1'b1, 32'h01020304, 1'b1);
    @(negedge clk_i);
    check("post_rst_rxack", 32'({rx_ack_l, rx_ack_m}), 32'd3);
    check("post_rst_idle_tx", 32'({tx_l, tx_m}), 32'd0);
    next_cycle();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < RATIO; i++) begin
      @(negedge clk_i);
      check($sformatf("post_rst_tx%0d", i), 32'({tx_l, tx_m}), 32'd3);
      check($sformatf("post_rst_lsb%0d", i), 32'(data_l), 32'(4 - i));
      check($sformatf("post_rst_msb%0d", i), 32'(data_m), 32'(i + 1));
      next_cycle();
    end
    @(negedge clk_i);
    check("post_rst_done_tx", 32'({tx_l, tx_m}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
